// File: rtl/edge_bit_unpacker_if.sv
// Handshake bundle between the packed-edge FIFO, the display pixel requester and edge_bit_unpacker.
// master = the unpacker, slave = the surrounding FIFO/display logic.
interface edge_bit_unpacker_if;
    logic        frame_start;
    logic        pix_rd_req;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        frame_done;

    modport master (
        input  frame_start, pix_rd_req, fifo_empty, fifo_rd_data,
        output fifo_rd_en, pix_data, pix_valid, underflow, frame_done
    );

    modport slave (
        output frame_start, pix_rd_req, fifo_empty, fifo_rd_data,
        input  fifo_rd_en, pix_data, pix_valid, underflow, frame_done
    );
endinterface

// File: rtl/edge_bit_unpacker.sv
// Expands 16-bit packed edge words (bit 15 first) into one RGB565 pixel per display request.
// Optional macro UNPACK_UNDERFLOW_RED_EN: underflow pixels are red (16'hF800) instead of BLACK.
module edge_bit_unpacker #(
    parameter logic [15:0] WHITE         = 16'hFFFF,
    parameter logic [15:0] BLACK         = 16'h0000,
    parameter int unsigned PIX_PER_FRAME = 307200
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    edge_bit_unpacker_if.master    bus
);

`ifdef UNPACK_UNDERFLOW_RED_EN
    localparam logic [15:0] UNDERFLOW_PIX = 16'hF800;
`else
    localparam logic [15:0] UNDERFLOW_PIX = BLACK;
`endif

    localparam logic [18:0] PIX_LAST = 19'(PIX_PER_FRAME - 1);

    typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

    fetch_state_t state, state_nxt;
    logic         fetch_capture;

    logic [15:0]  cur_word;
    logic [15:0]  pre_word;
    logic [3:0]   bit_cnt;
    logic         cur_valid;
    logic         pre_valid;
    logic [18:0]  pix_cnt;
    logic [18:0]  pix_cnt_base;

    logic         consume;
    logic         last_bit;
    logic         load_cur;

    function automatic logic [15:0] map_bit(input logic edge_bit);
        return edge_bit ? WHITE : BLACK;
    endfunction

    // Fetch FSM: a single outstanding pop, data returns one cycle later
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= F_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.fifo_rd_en = 1'b0;
        fetch_capture  = 1'b0;
        case (state)
            F_IDLE: begin
                // Gated by reset so the combinational pop stays low while the block is held in reset
                if (sys_rst_n && !pre_valid && !bus.fifo_empty && !bus.frame_start) begin
                    bus.fifo_rd_en = 1'b1;
                    state_nxt      = F_WAIT;
                end
            end
            F_WAIT: begin
                fetch_capture = 1'b1;
                state_nxt     = F_IDLE;
            end
            default: state_nxt = F_IDLE;
        endcase
    end

    // Bit consumption and word hand-over from prefetch to the shift register
    assign consume      = bus.pix_rd_req && cur_valid && !bus.frame_start;
    assign last_bit     = consume && (bit_cnt == 4'd15);
    assign load_cur     = !bus.frame_start && pre_valid && (!cur_valid || last_bit);
    assign pix_cnt_base = bus.frame_start ? 19'd0 : pix_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_valid <= 1'b0;
            pre_valid <= 1'b0;
            bit_cnt   <= 4'd0;
        end else begin
            if (bus.frame_start)  cur_valid <= 1'b0;
            else if (load_cur)    cur_valid <= 1'b1;
            else if (last_bit)    cur_valid <= 1'b0;

            if (bus.frame_start || load_cur) bit_cnt <= 4'd0;
            else if (consume)                bit_cnt <= bit_cnt + 4'd1;

            if (fetch_capture)    pre_valid <= 1'b1;
            else if (load_cur)    pre_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (fetch_capture) pre_word <= bus.fifo_rd_data;
        if (load_cur)      cur_word <= pre_word;
        else if (consume)  cur_word <= {cur_word[14:0], 1'b0};
    end

    // Output register: pixel, sticky underflow and frame counter, one cycle after the request
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.pix_valid  <= 1'b0;
            bus.pix_data   <= 16'h0000;
            bus.underflow  <= 1'b0;
            bus.frame_done <= 1'b0;
            pix_cnt        <= 19'd0;
        end else begin
            bus.pix_valid  <= bus.pix_rd_req;
            bus.frame_done <= 1'b0;
            pix_cnt        <= pix_cnt_base;

            if (bus.pix_rd_req) begin
                bus.pix_data <= consume ? map_bit(cur_word[15]) : UNDERFLOW_PIX;
                if (pix_cnt_base == PIX_LAST) begin
                    pix_cnt        <= 19'd0;
                    bus.frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt_base + 19'd1;
                end
            end

            // A request coinciding with frame_start is a flush, not a starvation event
            if (bus.frame_start)                        bus.underflow <= 1'b0;
            else if (bus.pix_rd_req && !cur_valid)      bus.underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_bit_unpacker.sv
// Randomized bench for edge_bit_unpacker: a bit-stream reference model predicts every pixel,
// frame_done and underflow; directed sequences cover pattern decode, flush and reset mid-fetch.
module tb_edge_bit_unpacker;

    localparam logic [15:0] W   = 16'hFFFF;
    localparam logic [15:0] B   = 16'h0000;
    localparam int          PPF = 32;
`ifdef UNPACK_UNDERFLOW_RED_EN
    localparam logic [15:0] UF  = 16'hF800;
`else
    localparam logic [15:0] UF  = B;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    edge_bit_unpacker_if bus();

    edge_bit_unpacker #(
        .WHITE(W), .BLACK(B), .PIX_PER_FRAME(PPF)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] fifo_q[$];
    bit          bits_q[$];
    int          pops     = 0;
    bit          pop_pending = 1'b0;
    bit          prev_rd_en  = 1'b0;

    // reference model state and expected outputs for the next edge
    bit          uf_m   = 1'b0;
    int          cnt_m  = 0;
    logic        exp_valid    = 1'b0;
    logic [15:0] exp_data     = 16'h0000;
    logic        exp_chk_data = 1'b1;
    logic        exp_fd       = 1'b0;
    logic        exp_uf       = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w);
        for (int b = 15; b >= 0; b--) bits_q.push_back(w[b]);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic model_step();
        bit b;
        int drop;
        if (!sys_rst_n) begin
            exp_valid = 1'b0; exp_data = 16'h0000; exp_chk_data = 1'b1;
            exp_fd = 1'b0; exp_uf = 1'b0; uf_m = 1'b0; cnt_m = 0;
            bits_q.delete();
            foreach (fifo_q[i]) for (int k = 15; k >= 0; k--) bits_q.push_back(fifo_q[i][k]);
            return;
        end
        exp_fd = 1'b0;
        exp_chk_data = 1'b0;
        if (bus.frame_start) begin
            drop = bits_q.size() % 16;
            for (int i = 0; i < drop; i++) void'(bits_q.pop_front());
            uf_m = 1'b0;
            cnt_m = 0;
        end
        if (bus.pix_rd_req) begin
            exp_valid = 1'b1;
            exp_chk_data = 1'b1;
            if (!bus.frame_start && bits_q.size() > 0) begin
                b = bits_q.pop_front();
                exp_data = b ? W : B;
            end else begin
                exp_data = UF;
                if (!bus.frame_start) uf_m = 1'b1;
            end
            cnt_m++;
            if (cnt_m == PPF) begin
                cnt_m = 0;
                exp_fd = 1'b1;
            end
        end else begin
            exp_valid = 1'b0;
        end
        exp_uf = uf_m;
    endtask

    task automatic tick();
        @(negedge sys_clk);
        check_eq("pix_valid", 32'(bus.pix_valid), 32'(exp_valid));
        if (exp_chk_data) check_eq("pix_data", 32'(bus.pix_data), 32'(exp_data));
        check_eq("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        check_eq("underflow", 32'(bus.underflow), 32'(exp_uf));
        check_eq("rd_en_back_to_back", 32'(bus.fifo_rd_en && prev_rd_en), 32'd0);
        if (!sys_rst_n) check_eq("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        prev_rd_en  = bus.fifo_rd_en;
        pop_pending = bus.fifo_rd_en;
        if (pop_pending) pops++;
        model_step();
        @(posedge sys_clk);
        #1;
        if (pop_pending && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        int p0;
        int n;
        bit seen;

        bus.frame_start  = 1'b0;
        bus.pix_rd_req   = 1'b0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = 16'h0000;
        #1 sys_rst_n = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // empty FIFO request: underflow pixel, sticky until frame_start
        bus.pix_rd_req = 1'b1; tick();
        bus.pix_rd_req = 1'b0; repeat (4) tick();
        bus.frame_start = 1'b1; tick();
        bus.frame_start = 1'b0; repeat (2) tick();

        // single word A5F0 decoded over 16 back-to-back requests
        p0 = pops;
        push_word(16'hA5F0);
        repeat (5) tick();
        bus.pix_rd_req = 1'b1; repeat (16) tick();
        bus.pix_rd_req = 1'b0; repeat (2) tick();
        check_eq("a5f0_pops", 32'(pops - p0), 32'd1);

        // FFFF,0000 over 32 requests from a fresh frame: no gap, two pops, frame_done on 32nd
        bus.frame_start = 1'b1; tick();
        bus.frame_start = 1'b0;
        p0 = pops;
        push_word(16'hFFFF);
        push_word(16'h0000);
        repeat (5) tick();
        bus.pix_rd_req = 1'b1; repeat (32) tick();
        bus.pix_rd_req = 1'b0; repeat (2) tick();
        check_eq("ffff0000_pops", 32'(pops - p0), 32'd2);

        // flush mid-word: rest of the word discarded, next word starts clean
        push_word(16'h8000);
        push_word(16'h8000);
        repeat (5) tick();
        bus.pix_rd_req = 1'b1; repeat (5) tick();
        bus.pix_rd_req = 1'b0; repeat (3) tick();
        bus.frame_start = 1'b1; tick();
        bus.frame_start = 1'b0; repeat (2) tick();
        bus.pix_rd_req = 1'b1; tick();
        bus.pix_rd_req = 1'b0; tick();
        bus.pix_rd_req = 1'b1; repeat (15) tick();
        bus.pix_rd_req = 1'b0; repeat (2) tick();

        // randomized rounds
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) push_word(16'($urandom()));
            repeat (5) tick();
            for (int c = 0; c < n * 16 + int'($urandom_range(0, 8)); c++) begin
                bus.pix_rd_req = ($urandom_range(0, 3) != 0);
                tick();
            end
            for (int g = 0; g < 64 && bits_q.size() > 0; g++) begin
                bus.pix_rd_req = 1'b1;
                tick();
            end
            for (int c = 0; c < 2; c++) begin
                bus.pix_rd_req = $urandom_range(0, 1);
                tick();
            end
            bus.frame_start = 1'b1;
            bus.pix_rd_req  = $urandom_range(0, 1);
            tick();
            bus.frame_start = 1'b0;
            bus.pix_rd_req  = 1'b0;
            tick();
        end

        // reset while a fetch is in flight
        push_word(16'h1234);
        push_word(16'hF00F);
        push_word(16'h5AA5);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = pop_pending;
        end
        check_eq("rst_fetch_seen", 32'(seen), 32'd1);
        sys_rst_n = 1'b0;
        p0 = pops;
        repeat (3) tick();
        check_eq("rst_no_pop", 32'(pops - p0), 32'd0);
        sys_rst_n = 1'b1;
        repeat (5) tick();
        check_eq("rst_pop_after_release", 32'(pops > p0), 32'd1);
        bus.pix_rd_req = 1'b1; repeat (34) tick();
        bus.pix_rd_req = 1'b0; repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
